// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Multi-cycle instruction sequencer that sits between an instruction source
//   and an ALU plus register file. It accepts one 16-bit instruction at a time
//   with a valid/ready handshake and walks it through IDLE -> DECODE -> EXEC
//   (-> WB for ALU-class instructions). Class 11 instructions are control
//   operations: NOP, HALT and conditional branches that test the flags
//   latched from the last ALU instruction.
//
// Instruction format:
//   [15:14] class   00 addressing, 01 arithmetic, 10 logic, 11 control
//   [13:10] opcode
//   [9:7]   operand 1 / destination register
//   [6:4]   operand 2 register
//   [3:0]   reserved
//
// Ports:
//   clk           single clock, all state changes on its rising edge
//   rst           synchronous, active-high reset
//   instr_valid   upstream presents an instruction on instr
//   instr         16-bit instruction word
//   instr_ready   high only in IDLE; a transfer needs valid and ready
//   za,zb,eq,gt,lt  live ALU flag outputs
//   ALU_opcode    opcode driven to the ALU (0000 when no ALU op is active)
//   ALU_OT        ALU output-type select (11 = none)
//   op1_regaddr   register-file read address, operand 1
//   op2_regaddr   register-file read address, operand 2
//   rf_we         register-file write enable, high for the WB cycle only
//   wb_addr       register-file write address
//   branch_taken  one-cycle pulse in EXEC of a taken branch
//   flags_q       {za,zb,eq,gt,lt} latched at the end of the last ALU EXEC
//   illegal       one-cycle pulse in EXEC of an undefined control opcode
//   halted        sequencer stopped by HALT until reset
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        za,
  input  logic        zb,
  input  logic        eq,
  input  logic        gt,
  input  logic        lt,
  output logic [3:0]  ALU_opcode,
  output logic [1:0]  ALU_OT,
  output logic [2:0]  op1_regaddr,
  output logic [2:0]  op2_regaddr,
  output logic        rf_we,
  output logic [2:0]  wb_addr,
  output logic        branch_taken,
  output logic [4:0]  flags_q,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [1:0] CLASS_CTRL = 2'b11;
  localparam logic [1:0] OT_NONE    = 2'b11;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BGT  = 4'b0011;
  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_BZA  = 4'b0101;

  // Bit positions inside flags_q = {za,zb,eq,gt,lt}
  localparam int FLAG_ZA = 4;
  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  state_t      state;
  logic [15:0] instr_q;

  logic [1:0]  cur_class;
  logic [3:0]  cur_opcode;
  logic        is_ctrl;
  logic        branch_cond;
  logic        opcode_undefined;
  logic [4:0]  live_flags;
  logic        unused_reserved;

  assign cur_class  = instr_q[15:14];
  assign cur_opcode = instr_q[13:10];
  assign is_ctrl    = (cur_class == CLASS_CTRL);
  assign live_flags = {za, zb, eq, gt, lt};

  // The reserved field is captured with the rest of the word but has no use.
  assign unused_reserved = ^instr_q[3:0];

  // Only IDLE can take a new instruction; anything offered elsewhere simply
  // waits on the bus until the sequencer comes back to IDLE.
  assign instr_ready = (state == IDLE);

  // Branch conditions look at the latched flags only, so the result does not
  // depend on whatever the ALU happens to be showing during the branch.
  always_comb begin
    branch_cond = 1'b0;
    case (cur_opcode)
      OP_BEQ:  branch_cond = flags_q[FLAG_EQ];
      OP_BGT:  branch_cond = flags_q[FLAG_GT];
      OP_BLT:  branch_cond = flags_q[FLAG_LT];
      OP_BZA:  branch_cond = flags_q[FLAG_ZA];
      default: branch_cond = 1'b0;
    endcase
  end

  // Control opcodes above BZA are undefined.
  assign opcode_undefined = (cur_opcode > OP_BZA);

  // Sequencer FSM. Every output is registered and updated on the transition
  // into the state where it must be visible, so values line up with the
  // state they belong to (e.g. rf_we is set on the EXEC->WB edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      instr_q      <= 16'h0000;
      flags_q      <= 5'b00000;
      ALU_OT       <= OT_NONE;
      ALU_opcode   <= OP_NOP;
      op1_regaddr  <= 3'd0;
      op2_regaddr  <= 3'd0;
      wb_addr      <= 3'd0;
      rf_we        <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised for a single state.
      rf_we        <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;

      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            // Read addresses come straight from the incoming word so they are
            // already valid during the DECODE cycle.
            op1_regaddr <= instr[9:7];
            op2_regaddr <= instr[6:4];
            state       <= DECODE;
          end
        end

        DECODE: begin
          state <= EXEC;
          if (is_ctrl) begin
            // Control resolves entirely in EXEC; the ALU stays unselected.
            branch_taken <= branch_cond;
            illegal      <= opcode_undefined;
          end else begin
            ALU_OT     <= cur_class;
            ALU_opcode <= cur_opcode;
          end
        end

        EXEC: begin
          if (is_ctrl) begin
            if (cur_opcode == OP_HALT) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state <= IDLE;
            end
          end else begin
            // The ALU result and its flags are valid during EXEC.
            flags_q <= live_flags;
            rf_we   <= 1'b1;
            wb_addr <= instr_q[9:7];
            state   <= WB;
          end
        end

        WB: begin
          ALU_OT     <= OT_NONE;
          ALU_opcode <= OP_NOP;
          state      <= IDLE;
        end

        HALT: begin
          // Absorbing until reset.
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Purpose:
//   Self-checking bench for alu_sequencer. Directed scenario tasks cover the
//   reset state, a single ALU op, taken / not-taken branches, illegal opcode,
//   HALT, reset in the middle of an instruction and back-to-back transfers.
//   A randomized task compares every output on every cycle against a
//   timeline model derived from the instruction's class and opcode.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        za, zb, eq, gt, lt;
  logic [3:0]  ALU_opcode;
  logic [1:0]  ALU_OT;
  logic [2:0]  op1_regaddr;
  logic [2:0]  op2_regaddr;
  logic        rf_we;
  logic [2:0]  wb_addr;
  logic        branch_taken;
  logic [4:0]  flags_q;
  logic        illegal;
  logic        halted;

  int checks = 0;
  int errors = 0;

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .za           (za),
    .zb           (zb),
    .eq           (eq),
    .gt           (gt),
    .lt           (lt),
    .ALU_opcode   (ALU_opcode),
    .ALU_OT       (ALU_OT),
    .op1_regaddr  (op1_regaddr),
    .op2_regaddr  (op2_regaddr),
    .rf_we        (rf_we),
    .wb_addr      (wb_addr),
    .branch_taken (branch_taken),
    .flags_q      (flags_q),
    .illegal      (illegal),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot of every observable output, packed for whole-cycle comparison.
  typedef struct packed {
    logic       ready;
    logic [1:0] ot;
    logic [3:0] opc;
    logic [2:0] op1;
    logic [2:0] op2;
    logic       we;
    logic [2:0] wba;
    logic       bt;
    logic [4:0] flags;
    logic       ill;
    logic       hlt;
  } obs_t;

  localparam obs_t RESET_OBS = '{ready: 1'b1, ot: 2'b11, opc: 4'd0, op1: 3'd0,
                                 op2: 3'd0, we: 1'b0, wba: 3'd0, bt: 1'b0,
                                 flags: 5'd0, ill: 1'b0, hlt: 1'b0};

  function automatic obs_t sample();
    obs_t a;
    a = {instr_ready, ALU_OT, ALU_opcode, op1_regaddr, op2_regaddr, rf_we,
         wb_addr, branch_taken, flags_q, illegal, halted};
    return a;
  endfunction

  // Reference timeline. k counts clock edges after the accept edge
  // (k=1 first cycle after acceptance). ALU-class instructions take four
  // cycles to return to IDLE, control ones three.
  function automatic logic branch_taken_model(logic [3:0] opc, logic [4:0] fl);
    // fl = {za,zb,eq,gt,lt}
    case (opc)
      4'd2:    return fl[2];
      4'd3:    return fl[1];
      4'd4:    return fl[0];
      4'd5:    return fl[4];
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t model_cycle(logic [15:0] ins, int k, logic [4:0] fl_before,
                                       logic [4:0] fl_live, logic [2:0] prev_wb);
    obs_t e;
    logic [1:0] cls;
    logic [3:0] opc;
    cls     = ins[15:14];
    opc     = ins[13:10];
    e.ready = 1'b0;
    e.ot    = 2'b11;
    e.opc   = 4'd0;
    e.op1   = ins[9:7];
    e.op2   = ins[6:4];
    e.we    = 1'b0;
    e.wba   = prev_wb;
    e.bt    = 1'b0;
    e.flags = fl_before;
    e.ill   = 1'b0;
    e.hlt   = 1'b0;
    if (cls == 2'b11) begin
      if (k == 2) begin
        e.bt  = branch_taken_model(opc, fl_before);
        e.ill = (opc >= 4'd6);
      end
      if (k >= 3) begin
        e.hlt   = (opc == 4'd1);
        e.ready = (opc != 4'd1);
      end
    end else begin
      if (k == 2 || k == 3) begin
        e.ot  = cls;
        e.opc = opc;
      end
      if (k >= 3) begin
        e.flags = fl_live;
        e.wba   = ins[9:7];
      end
      if (k == 3) e.we = 1'b1;
      if (k >= 4) e.ready = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {za, zb, eq, gt, lt} = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for ready, presents ins for one accept edge, and returns
  // one cycle after acceptance (k=1).
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_timeout ins=%h instr_ready=%b required=1", ins, instr_ready);
    end
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a;
    do_reset();
    a = sample();
    checks++;
    if (a !== RESET_OBS) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h required=%h", a, RESET_OBS);
    end
  endtask

  task automatic test_alu_op();
    set_flags(5'b01010);
    issue(16'h4A90);
    checks++;
    if (op1_regaddr !== 3'd5 || op2_regaddr !== 3'd1) begin
      errors++;
      $display("[TB] FAIL alu_decode_addr got=%0d/%0d required=5/1", op1_regaddr, op2_regaddr);
    end
    tick();
    checks++;
    if (ALU_OT !== 2'b01 || ALU_opcode !== 4'b0010 || rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_exec got ot=%b opc=%b we=%b required ot=01 opc=0010 we=0",
               ALU_OT, ALU_opcode, rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 1'b1 || wb_addr !== 3'd5 || instr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_wb got we=%b wba=%0d ready=%b required we=1 wba=5 ready=0",
               rf_we, wb_addr, instr_ready);
    end
    tick();
    checks++;
    if (instr_ready !== 1'b1 || rf_we !== 1'b0 || flags_q !== 5'b01010 || ALU_OT !== 2'b11) begin
      errors++;
      $display("[TB] FAIL alu_done got ready=%b we=%b flags=%b ot=%b required 1 0 01010 11",
               instr_ready, rf_we, flags_q, ALU_OT);
    end
  endtask

  task automatic test_branch_taken();
    set_flags(5'b00100);
    issue(16'h8190);
    tick();
    tick();
    tick();
    set_flags(5'b00000);
    issue(16'hC800);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (branch_taken !== (k == 2) || rf_we !== 1'b0 || ALU_OT !== 2'b11) begin
        errors++;
        $display("[TB] FAIL beq_k%0d got bt=%b we=%b ot=%b required bt=%b we=0 ot=11",
                 k, branch_taken, rf_we, ALU_OT, (k == 2));
      end
      if (k < 3) tick();
    end
  endtask

  task automatic test_not_taken();
    set_flags(5'b00100);
    issue(16'h8190);
    tick();
    tick();
    tick();
    set_flags(5'b00010);
    issue(16'hCC00);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (branch_taken !== 1'b0 || instr_ready !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL bgt_k%0d got bt=%b ready=%b required bt=0 ready=%b",
                 k, branch_taken, instr_ready, (k == 3));
      end
      if (k < 3) tick();
    end
  endtask

  task automatic test_illegal_halt();
    // flags_q currently 00100 from the preceding logic op.
    set_flags(5'b11111);
    issue(16'hFC00);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (illegal !== (k == 2) || flags_q !== 5'b00100 || rf_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_k%0d got ill=%b flags=%b we=%b required ill=%b flags=00100 we=0",
                 k, illegal, flags_q, rf_we, (k == 2));
      end
      if (k < 3) tick();
    end
    instr       = 16'hC400;
    instr_valid = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (rf_we !== 1'b0 || (k >= 3 && (halted !== 1'b1 || instr_ready !== 1'b0))) begin
        errors++;
        $display("[TB] FAIL halt_k%0d got halted=%b ready=%b we=%b", k, halted, instr_ready, rf_we);
      end
      tick();
    end
    instr_valid = 1'b0;
    do_reset();
    checks++;
    if (halted !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_exit got halted=%b ready=%b required 0 1", halted, instr_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t a;
    set_flags(5'b10001);
    issue(16'h4A90);
    tick();
    rst = 1'b1;
    tick();
    a = sample();
    checks++;
    if (a !== RESET_OBS) begin
      errors++;
      $display("[TB] FAIL reset_mid_op got=%h required=%h", a, RESET_OBS);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rf_we !== 1'b0 || instr_ready !== 1'b1 || flags_q !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op_after got we=%b ready=%b flags=%b required 0 1 00000",
               rf_we, instr_ready, flags_q);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_we;
    logic exp_ready;
    logic [2:0] exp_op1;
    set_flags(5'b00000);
    instr       = 16'h4A90;
    instr_valid = 1'b1;
    tick();
    instr = 16'h0B30;
    for (int k = 1; k <= 8; k++) begin
      exp_we    = (k == 3 || k == 7);
      exp_ready = (k == 4 || k == 8);
      exp_op1   = (k <= 4) ? 3'd5 : 3'd6;
      checks++;
      if (rf_we !== exp_we || instr_ready !== exp_ready || op1_regaddr !== exp_op1 ||
          (exp_we && wb_addr !== exp_op1)) begin
        errors++;
        $display("[TB] FAIL b2b_k%0d got we=%b ready=%b op1=%0d wba=%0d required we=%b ready=%b op1=%0d",
                 k, rf_we, instr_ready, op1_regaddr, wb_addr, exp_we, exp_ready, exp_op1);
      end
      if (k == 5) instr_valid = 1'b0;
      if (k < 8) tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [4:0]  live;
    logic [4:0]  m_flags;
    logic [2:0]  m_wb;
    int          len;
    obs_t        e;
    obs_t        a;
    do_reset();
    m_flags = 5'd0;
    m_wb    = 3'd0;
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      if (ins[15:14] == 2'b11 && ins[13:10] == 4'd1) ins[13:10] = 4'd0;
      live = 5'($urandom);
      set_flags(live);
      issue(ins);
      len = (ins[15:14] == 2'b11) ? 3 : 4;
      for (int k = 1; k <= len; k++) begin
        e = model_cycle(ins, k, m_flags, live, m_wb);
        a = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("[TB] FAIL rand_i%0d_k%0d ins=%h got=%h required=%h", i, k, ins, a, e);
        end
        if (k < len) tick();
      end
      if (ins[15:14] != 2'b11) begin
        m_flags = live;
        m_wb    = ins[9:7];
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    set_flags(5'b00000);
    test_reset();
    test_alu_op();
    test_branch_taken();
    test_not_taken();
    test_illegal_halt();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
